// File: rtl/audio_adc_rx.sv
// Audio codec ADC receiver: left-justified serial capture of stereo words,
// frame-length error detection with a saturating error counter, and a
// decaying peak meter driving an 8-LED thermometer display.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int DECAY_SHIFT = 6
) (
  input  logic                  CLOCK_27,
  input  logic                  Reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] LEFT_DATA,
  output logic [DATA_WIDTH-1:0] RIGHT_DATA,
  output logic                  SAMPLE_VALID,
  output logic                  FRAME_ERR,
  output logic [7:0]            ERR_COUNT,
  output logic [7:0]            LEVEL
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    CAP_L     = 2'd1,
    CAP_R     = 2'd2
  } state_t;

  // Magnitude of a two's complement word; the most negative code maps to the
  // most positive one so the result always fits in DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] most_neg;
    most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (x == most_neg) begin
      abs_sat = ~most_neg;
    end else if (x[DATA_WIDTH-1]) begin
      abs_sat = (~x) + DATA_WIDTH'(1);
    end else begin
      abs_sat = x;
    end
  endfunction

  logic [2:0]            bclk_sync_r;
  logic [1:0]            lrck_sync_r;
  logic [1:0]            dat_sync_r;
  logic                  bit_evt_s;
  logic                  bit_evt_r;
  logic                  lrck_bit_r;
  logic                  dat_bit_r;
  logic                  lrck_prev_r;
  logic                  ref_vld_r;
  logic                  word_start_s;
  state_t                state_r;
  state_t                state_s;
  logic                  load_s;
  logic                  shift_s;
  logic                  err_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_nxt_s;
  logic                  left_done_s;
  logic                  right_done_s;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  left_ok_r;
  logic                  pair_done_r;
  logic                  err_pend_r;
  logic [DATA_WIDTH-1:0] mag_l_s;
  logic [DATA_WIDTH-1:0] mag_r_s;
  logic [DATA_WIDTH-1:0] mag_s;
  logic [DATA_WIDTH-1:0] peak_r;
  logic [DATA_WIDTH-1:0] peak_nxt_s;
  logic [7:0]            level_s;

  // Bring the codec signals into the CLOCK_27 domain; the third BCLK flop
  // provides the previous value for rising-edge detection.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      bclk_sync_r <= 3'b000;
      lrck_sync_r <= 2'b00;
      dat_sync_r  <= 2'b00;
    end else begin
      bclk_sync_r <= {bclk_sync_r[1:0], AUD_BCLK};
      lrck_sync_r <= {lrck_sync_r[0], AUD_ADCLRCK};
      dat_sync_r  <= {dat_sync_r[0], AUD_ADCDAT};
    end
  end

  assign bit_evt_s = bclk_sync_r[1] & ~bclk_sync_r[2];

  // Register the bit event together with the LRCK/DAT values it samples.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      bit_evt_r  <= 1'b0;
      lrck_bit_r <= 1'b0;
      dat_bit_r  <= 1'b0;
    end else begin
      bit_evt_r  <= bit_evt_s;
      lrck_bit_r <= lrck_sync_r[1];
      dat_bit_r  <= dat_sync_r[1];
    end
  end

  // Remember LRCK at the last bit event; the first one after reset only
  // seeds the reference and can never look like a word start.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      lrck_prev_r <= 1'b0;
      ref_vld_r   <= 1'b0;
    end else if (bit_evt_r) begin
      lrck_prev_r <= lrck_bit_r;
      ref_vld_r   <= 1'b1;
    end
  end

  assign word_start_s = bit_evt_r & ref_vld_r & (lrck_bit_r != lrck_prev_r);

  // Channel state register.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      state_r <= WAIT_SYNC;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, word framing decisions and the shifter/counter next values.
  always_comb begin
    state_s      = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    err_s        = 1'b0;
    cnt_nxt_s    = cnt_r;
    shift_nxt_s  = shift_r;
    left_done_s  = 1'b0;
    right_done_s = 1'b0;
    case (state_r)
      WAIT_SYNC: begin
        if (word_start_s && lrck_bit_r) begin
          state_s = CAP_L;
          load_s  = 1'b1;
        end else begin
          state_s = WAIT_SYNC;
        end
      end
      CAP_L, CAP_R: begin
        if (word_start_s) begin
          state_s = lrck_bit_r ? CAP_L : CAP_R;
          load_s  = 1'b1;
          err_s   = (cnt_r != CNT_ZERO) && (cnt_r < CNT_FULL);
        end else if (bit_evt_r && (cnt_r < CNT_FULL)) begin
          shift_s = 1'b1;
        end else begin
          shift_s = 1'b0;
        end
      end
      default: begin
        state_s = WAIT_SYNC;
      end
    endcase
    if (load_s) begin
      cnt_nxt_s   = CNT_ONE;
      shift_nxt_s = {{(DATA_WIDTH-1){1'b0}}, dat_bit_r};
    end else if (shift_s) begin
      cnt_nxt_s   = cnt_r + CNT_ONE;
      shift_nxt_s = {shift_r[DATA_WIDTH-2:0], dat_bit_r};
    end else begin
      cnt_nxt_s   = cnt_r;
      shift_nxt_s = shift_r;
    end
    if ((load_s || shift_s) && (cnt_nxt_s == CNT_FULL)) begin
      left_done_s  = (state_s == CAP_L);
      right_done_s = (state_s == CAP_R);
    end else begin
      left_done_s  = 1'b0;
      right_done_s = 1'b0;
    end
  end

  // Shifter, bit counter, left holding register and pair/error pending flags.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      cnt_r       <= CNT_ZERO;
      shift_r     <= {DATA_WIDTH{1'b0}};
      hold_r      <= {DATA_WIDTH{1'b0}};
      left_ok_r   <= 1'b0;
      pair_done_r <= 1'b0;
      err_pend_r  <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      pair_done_r <= right_done_s & left_ok_r & ~err_s;
      err_pend_r  <= err_s;
      if (err_s) begin
        left_ok_r <= 1'b0;
      end else if (left_done_s) begin
        hold_r    <= shift_nxt_s;
        left_ok_r <= 1'b1;
      end else if (right_done_s) begin
        left_ok_r <= 1'b0;
      end
    end
  end

  // Publish a completed stereo pair or a framing error; errors win.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      LEFT_DATA    <= {DATA_WIDTH{1'b0}};
      RIGHT_DATA   <= {DATA_WIDTH{1'b0}};
      SAMPLE_VALID <= 1'b0;
      FRAME_ERR    <= 1'b0;
      ERR_COUNT    <= 8'd0;
    end else begin
      FRAME_ERR    <= err_pend_r;
      SAMPLE_VALID <= pair_done_r & ~err_pend_r;
      if (pair_done_r && !err_pend_r) begin
        LEFT_DATA  <= hold_r;
        RIGHT_DATA <= shift_r;
      end
      if (err_pend_r && (ERR_COUNT != 8'hFF)) begin
        ERR_COUNT <= ERR_COUNT + 8'd1;
      end
    end
  end

  // Peak candidate: jump up to a louder sample, otherwise decay geometrically.
  always_comb begin
    mag_l_s = abs_sat(LEFT_DATA);
    mag_r_s = abs_sat(RIGHT_DATA);
    if (mag_l_s > mag_r_s) begin
      mag_s = mag_l_s;
    end else begin
      mag_s = mag_r_s;
    end
    if (mag_s > peak_r) begin
      peak_nxt_s = mag_s;
    end else begin
      peak_nxt_s = peak_r - (peak_r >> DECAY_SHIFT);
    end
  end

  // Peak register advances once per published sample.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      peak_r <= {DATA_WIDTH{1'b0}};
    end else if (SAMPLE_VALID) begin
      peak_r <= peak_nxt_s;
    end
  end

  // Thermometer thresholds at 128, 256, ... 16384.
  always_comb begin
    level_s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      level_s[i] = (32'(peak_r) >= (32'd128 << i));
    end
  end

  // LED output register.
  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      LEVEL <= 8'h00;
    end else begin
      LEVEL <= level_s;
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: drives a serial codec stream phase by phase and
// compares published samples, errors and the LED meter with a phase-level
// reference model.
module tb_audio_adc_rx;

  localparam int DW = 16;
  localparam int DS = 6;

  logic          CLOCK_27    = 1'b0;
  logic          Reset       = 1'b0;
  logic          AUD_BCLK    = 1'b0;
  logic          AUD_ADCLRCK = 1'b0;
  logic          AUD_ADCDAT  = 1'b0;
  logic [DW-1:0] LEFT_DATA;
  logic [DW-1:0] RIGHT_DATA;
  logic          SAMPLE_VALID;
  logic          FRAME_ERR;
  logic [7:0]    ERR_COUNT;
  logic [7:0]    LEVEL;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] obs_q[$];
  int obs_err_pulses = 0;
  int exp_err_pulses = 0;
  int exp_err_cnt    = 0;
  bit both_seen      = 1'b0;

  bit            m_synced;
  int            m_prev_n;
  bit            m_left_ok;
  logic [DW-1:0] m_hold;
  int            m_peak;

  audio_adc_rx #(.DATA_WIDTH(DW), .DECAY_SHIFT(DS)) dut (
    .CLOCK_27     (CLOCK_27),
    .Reset        (Reset),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .LEFT_DATA    (LEFT_DATA),
    .RIGHT_DATA   (RIGHT_DATA),
    .SAMPLE_VALID (SAMPLE_VALID),
    .FRAME_ERR    (FRAME_ERR),
    .ERR_COUNT    (ERR_COUNT),
    .LEVEL        (LEVEL)
  );

  always #19 CLOCK_27 = ~CLOCK_27;

  initial begin
    #(38 * 90000);
    $display("FAIL watchdog: simulation still running, limit 90000 cycles");
    $fatal(1);
  end

  // Collect DUT pulses away from the active edge.
  always @(negedge CLOCK_27) begin
    if (Reset) begin
      if (SAMPLE_VALID) obs_q.push_back({LEFT_DATA, RIGHT_DATA});
      if (FRAME_ERR) obs_err_pulses++;
      if (SAMPLE_VALID && FRAME_ERR) both_seen = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int mag_of(input logic [DW-1:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
    return s;
  endfunction

  function automatic logic [7:0] model_level();
    logic [7:0] lv;
    lv = 8'h00;
    for (int i = 0; i < 8; i++) lv[i] = (m_peak >= (128 << i));
    return lv;
  endfunction

  function automatic void model_reset();
    m_synced    = 1'b0;
    m_prev_n    = 0;
    m_left_ok   = 1'b0;
    m_hold      = '0;
    m_peak      = 0;
    exp_err_cnt = 0;
  endfunction

  function automatic void model_sample(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int mag;
    exp_q.push_back({l, r});
    mag = (mag_of(l) > mag_of(r)) ? mag_of(l) : mag_of(r);
    if (mag > m_peak) m_peak = mag;
    else m_peak = m_peak - (m_peak >> DS);
  endfunction

  // One LRCK phase beginning with an LRCK change: lr channel, n bits, first DW bits = w.
  function automatic void model_phase(input bit lr, input int n, input logic [DW-1:0] w);
    if (m_synced) begin
      if (m_prev_n < DW) begin
        exp_err_pulses++;
        if (exp_err_cnt < 255) exp_err_cnt++;
        m_left_ok = 1'b0;
      end
    end else if (lr) begin
      m_synced = 1'b1;
    end else begin
      return;
    end
    m_prev_n = n;
    if (n >= DW) begin
      if (lr) begin
        m_hold    = w;
        m_left_ok = 1'b1;
      end else if (m_left_ok) begin
        model_sample(m_hold, w);
        m_left_ok = 1'b0;
      end
    end
  endfunction

  task automatic send_bit(input bit lr, input bit d, input bit measure);
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat ($urandom_range(4, 6)) @(negedge CLOCK_27);
    AUD_BCLK = 1'b1;
    if (measure) begin
      @(posedge CLOCK_27);
      repeat (3) @(posedge CLOCK_27);
      #1 check_eq("latency_e3", {31'd0, SAMPLE_VALID}, 32'd0);
      @(posedge CLOCK_27);
      #1 check_eq("latency_e4", {31'd0, SAMPLE_VALID}, 32'd1);
      @(negedge CLOCK_27);
    end else begin
      repeat ($urandom_range(4, 6)) @(negedge CLOCK_27);
    end
    AUD_BCLK = 1'b0;
  endtask

  task automatic send_phase(input bit lr, input int n, input logic [DW-1:0] w, input bit measure);
    bit d;
    for (int i = 0; i < n; i++) begin
      if (i < DW) d = w[DW-1-i];
      else d = 1'($urandom_range(0, 1));
      send_bit(lr, d, measure && (i == DW - 1));
    end
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int n, input bit measure);
    send_phase(1'b1, n, l, 1'b0);
    model_phase(1'b1, n, l);
    send_phase(1'b0, n, r, measure);
    model_phase(1'b0, n, r);
  endtask

  task automatic checkpoint(input string tag);
    repeat (12) @(negedge CLOCK_27);
    check_eq({tag, "_nsamp"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq({tag, "_sample"}, obs_q[i], exp_q[i]);
    check_eq({tag, "_errpulses"}, obs_err_pulses, exp_err_pulses);
    check_eq({tag, "_errcount"}, {24'd0, ERR_COUNT}, exp_err_cnt);
    obs_q.delete();
    exp_q.delete();
    obs_err_pulses = 0;
    exp_err_pulses = 0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_27);
    Reset = 1'b0;
    repeat (4) @(negedge CLOCK_27);
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge CLOCK_27);
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int n;
    model_reset();
    repeat (5) @(negedge CLOCK_27);
    check_eq("rst_left",  {16'd0, LEFT_DATA}, 32'd0);
    check_eq("rst_right", {16'd0, RIGHT_DATA}, 32'd0);
    check_eq("rst_valid", {31'd0, SAMPLE_VALID}, 32'd0);
    check_eq("rst_ferr",  {31'd0, FRAME_ERR}, 32'd0);
    check_eq("rst_errcnt", {24'd0, ERR_COUNT}, 32'd0);
    check_eq("rst_level", {24'd0, LEVEL}, 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge CLOCK_27);

    // Reference phase, then the basic pair with latency measurement.
    send_phase(1'b0, DW, 16'($urandom), 1'b0);
    frame(16'h1234, 16'hFEDC, DW, 1'b1);
    checkpoint("basic");

    // Random pairs, some phases carrying trailing junk bits.
    for (int k = 0; k < 20; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? DW + $urandom_range(1, 6) : DW;
      frame(a, b, n, 1'b0);
    end
    frame(16'hABCD, 16'hABCD, 20, 1'b0);
    checkpoint("random");

    // Left phase cut short, followed by a clean frame.
    a = 16'($urandom);
    send_phase(1'b1, 10, a, 1'b0);
    model_phase(1'b1, 10, a);
    b = 16'($urandom);
    send_phase(1'b0, DW, b, 1'b0);
    model_phase(1'b0, DW, b);
    frame(16'h0F0F, 16'hF0F0, DW, 1'b0);
    checkpoint("trunc");

    // Reset while the right word is in flight.
    a = 16'($urandom);
    send_phase(1'b1, DW, a, 1'b0);
    model_phase(1'b1, DW, a);
    checkpoint("pre_rst");
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    @(negedge CLOCK_27);
    Reset = 1'b0;
    repeat (4) @(negedge CLOCK_27);
    check_eq("midrst_left", {16'd0, LEFT_DATA}, 32'd0);
    check_eq("midrst_errcnt", {24'd0, ERR_COUNT}, 32'd0);
    check_eq("midrst_level", {24'd0, LEVEL}, 32'd0);
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge CLOCK_27);
    for (int i = 0; i < 9; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    frame(16'h7FFF, 16'h8000, DW, 1'b0);
    frame(16'h7FFF, 16'h8000, DW, 1'b0);
    checkpoint("rst_mid");
    check_eq("rst_mid_level", {24'd0, LEVEL}, {24'd0, model_level()});

    // Peak decay after one loud frame.
    do_reset();
    send_phase(1'b0, DW, 16'($urandom), 1'b0);
    frame(16'h4000, 16'h4000, DW, 1'b0);
    repeat (6) @(negedge CLOCK_27);
    check_eq("decay_loud", {24'd0, LEVEL}, {24'd0, model_level()});
    for (int k = 0; k < 64; k++) begin
      frame(16'h0000, 16'h0000, DW, 1'b0);
      repeat (6) @(negedge CLOCK_27);
      check_eq("decay_level", {24'd0, LEVEL}, {24'd0, model_level()});
    end
    checkpoint("decay");

    // Long run of short words to saturate the error counter.
    for (int k = 0; k < 302; k++) begin
      n = $urandom_range(1, 4);
      a = 16'($urandom);
      send_phase(1'((k + 1) % 2), n, a, 1'b0);
      model_phase(1'((k + 1) % 2), n, a);
    end
    checkpoint("saturate");

    check_eq("valid_err_exclusive", {31'd0, both_seen}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
